// File: rtl/fcfs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fcfs_pkg
// Brief    : Shared types, defaults and one-hot helper for the grant sequencer.
// Revision : 1.0
// ============================================================================
package fcfs_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int LENW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0] idx;
    logic       valid;
  } onehot_t;

  // valid is set only when exactly one bit of vec is high
  function automatic onehot_t onehot_idx(input logic [31:0] vec);
    onehot_t r;
    int      cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) begin
        r.idx = 5'(i);
        cnt++;
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fcfs_grant_decode.sv
`default_nettype none
// ============================================================================
// Module   : fcfs_grant_decode
// Brief    : Combinational one-hot check and index encode of the grant vector.
// Revision : 1.0
// ============================================================================
module fcfs_grant_decode
  import fcfs_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         i_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_is_onehot,
  output logic                    o_is_multihot
);

  localparam int c_IW = $clog2(NREQ);

  onehot_t w_res;

  always_comb begin
    w_res         = onehot_idx(32'(i_grant));
    o_idx         = c_IW'(w_res.idx);
    o_is_onehot   = w_res.valid;
    o_is_multihot = (|i_grant) && !w_res.valid;
  end

endmodule
`default_nettype wire

// File: rtl/fcfs_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fcfs_grant_sequencer
// Brief    : Turns a one-hot FCFS grant into a bounded valid/ready burst.
// Revision : 1.0
// ============================================================================
module fcfs_grant_sequencer
  import fcfs_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         grant,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ*LENW-1:0]    req_len,
  output logic [NREQ-1:0]         data_ack,
  output logic [NREQ-1:0]         done,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [1:0]              err
);

  localparam int c_IW = $clog2(NREQ);

  state_t            r_state, w_state_nxt;
  logic [c_IW-1:0]   r_owner, w_owner_nxt;
  logic [LENW-1:0]   r_beats, w_beats_nxt;
  logic              r_valid, w_valid_nxt;
  logic [DW-1:0]     r_data,  w_data_nxt;
  logic              r_last,  w_last_nxt;
  logic [NREQ-1:0]   r_ack,   w_ack_nxt;
  logic [NREQ-1:0]   r_done,  w_done_nxt;
  logic              r_busy,  w_busy_nxt;
  logic [1:0]        r_err,   w_err_nxt;

  logic [c_IW-1:0]   w_dec_idx;
  logic              w_dec_onehot;
  logic              w_dec_multihot;
  logic [NREQ-1:0]   w_owner_mask;
  logic [DW-1:0]     w_owner_data;
  logic [DW-1:0]     w_new_data;
  logic [LENW-1:0]   w_new_len;
  logic              w_grant_lost;

  fcfs_grant_decode #(.NREQ(NREQ)) u_decode (
    .i_grant       (grant),
    .o_idx         (w_dec_idx),
    .o_is_onehot   (w_dec_onehot),
    .o_is_multihot (w_dec_multihot)
  );

  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
    w_owner_data          = req_data[r_owner*DW +: DW];
    w_new_data            = req_data[w_dec_idx*DW +: DW];
    w_new_len             = req_len[w_dec_idx*LENW +: LENW];
    w_grant_lost          = ((grant & w_owner_mask) == '0) || ((grant & ~w_owner_mask) != '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beats_nxt = r_beats;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_dec_onehot) begin
          w_owner_nxt = w_dec_idx;
          w_beats_nxt = w_new_len;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_new_data;
          w_last_nxt  = (w_new_len == '0);
          w_state_nxt = S_XFER;
        end else if (w_dec_multihot) begin
          w_err_nxt[0] = 1'b1;
        end
      end
      S_XFER: begin
        // a vanished or contested grant aborts the burst without a done pulse
        if (w_grant_lost) begin
          w_err_nxt[1] = 1'b1;
          w_valid_nxt  = 1'b0;
          w_last_nxt   = 1'b0;
          w_state_nxt  = S_RELEASE;
        end else if (r_valid && out_ready) begin
          w_ack_nxt = w_owner_mask;
          if (r_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            if (r_beats != '0) begin
              w_beats_nxt = r_beats - 1'b1;
            end
            w_last_nxt = (r_beats == LENW'(1));
            w_data_nxt = w_owner_data;
          end
        end else begin
          w_data_nxt = w_owner_data;
        end
      end
      S_DONE: begin
        w_done_nxt  = w_owner_mask;
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (grant == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_beats <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_ack   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beats <= w_beats_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign data_ack  = r_ack;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_owner;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fcfs_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcfs_grant_sequencer
// Brief    : Directed self-checking bench for fcfs_grant_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fcfs_grant_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  grant;
  logic [31:0] req_data;
  logic [15:0] req_len;
  logic [3:0]  data_ack;
  logic [3:0]  done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic [1:0]  err;

  int n_checks = 0;
  int n_errors = 0;

  fcfs_grant_sequencer #(.NREQ(4), .DW(8), .LENW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .grant     (grant),
    .req_data  (req_data),
    .req_len   (req_len),
    .data_ack  (data_ack),
    .done      (done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [3:0] len);
    req_len[idx*4 +: 4] = len;
  endtask

  initial begin
    reset     = 1'b1;
    grant     = 4'b0000;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_len   = 16'h0000;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ack", data_ack, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);

    // owner 1, three beats with ready held high
    grant = 4'b0010; set_len(1, 4'd2); out_ready = 1'b1;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_id", out_id, 1);
    check("t1_data", out_data, 8'hB1);
    check("t1_last0", out_last, 0);
    check("t1_busy", busy, 1);
    check("t1_ack0", data_ack, 0);
    tick();
    check("t1_ack1", data_ack, 4'b0010);
    check("t1_last1", out_last, 0);
    tick();
    check("t1_ack2", data_ack, 4'b0010);
    check("t1_last2", out_last, 1);
    check("t1_valid2", out_valid, 1);
    tick();
    check("t1_ack3", data_ack, 4'b0010);
    check("t1_valid3", out_valid, 0);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 4'b0010);
    check("t1_ack_after", data_ack, 0);
    tick();
    check("t1_done_once", done, 0);
    check("t1_busy_hold", busy, 1);
    check("t1_no_rerun", out_valid, 0);
    grant = 4'b0000;
    tick();
    check("t1_idle", busy, 0);

    // owner 0, single beat with ready stalled
    grant = 4'b0001; set_len(0, 4'd0); out_ready = 1'b0;
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_last", out_last, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_data", out_data, 8'hA0);
      check("t2_hold_ack", data_ack, 0);
    end
    out_ready = 1'b1;
    tick();
    check("t2_ack", data_ack, 4'b0001);
    check("t2_valid_off", out_valid, 0);
    tick();
    check("t2_done", done, 4'b0001);
    grant = 4'b0000;
    tick();
    check("t2_idle", busy, 0);

    // multi-hot grant in IDLE
    grant = 4'b0101;
    tick();
    check("t3_err", err, 2'b01);
    check("t3_valid", out_valid, 0);
    check("t3_busy", busy, 0);
    tick();
    check("t3_still_idle", busy, 0);
    grant = 4'b0000;

    // owner 2 loses its grant after one beat
    grant = 4'b0100; set_len(2, 4'd3); out_ready = 1'b1;
    tick();
    check("t4_valid", out_valid, 1);
    check("t4_id", out_id, 2);
    check("t4_data", out_data, 8'hC2);
    tick();
    check("t4_ack1", data_ack, 4'b0100);
    grant = 4'b0000; out_ready = 1'b0;
    tick();
    check("t4_err", err, 2'b11);
    check("t4_valid_off", out_valid, 0);
    check("t4_no_ack", data_ack, 0);
    check("t4_no_done", done, 0);
    tick();
    check("t4_no_done2", done, 0);
    check("t4_idle", busy, 0);

    // owner 3 then owner 2, grant to 3 held after completion
    grant = 4'b1000; set_len(3, 4'd1); out_ready = 1'b1;
    tick();
    check("t5_valid3", out_valid, 1);
    check("t5_id3", out_id, 3);
    check("t5_data3", out_data, 8'hD3);
    tick();
    check("t5_ack3a", data_ack, 4'b1000);
    check("t5_last3", out_last, 1);
    tick();
    check("t5_ack3b", data_ack, 4'b1000);
    tick();
    check("t5_done3", done, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_dup_valid", out_valid, 0);
      check("t5_no_dup_ack", data_ack, 0);
      check("t5_hold_busy", busy, 1);
    end
    grant = 4'b0000;
    tick();
    check("t5_idle", busy, 0);
    grant = 4'b0100; set_len(2, 4'd0);
    tick();
    check("t5_valid2", out_valid, 1);
    check("t5_id2", out_id, 2);
    check("t5_last2", out_last, 1);
    tick();
    check("t5_ack2", data_ack, 4'b0100);
    tick();
    check("t5_done2", done, 4'b0100);
    grant = 4'b0000;
    tick();
    check("t5_idle2", busy, 0);

    // reset during beat 2 of a 4-beat burst
    grant = 4'b0010; set_len(1, 4'd3); out_ready = 1'b1;
    tick();
    check("t6_valid", out_valid, 1);
    tick();
    check("t6_ack1", data_ack, 4'b0010);
    reset = 1'b1; grant = 4'b0000;
    tick();
    check("t6_valid_rst", out_valid, 0);
    check("t6_err_rst", err, 0);
    check("t6_ack_rst", data_ack, 0);
    check("t6_done_rst", done, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_last_rst", out_last, 0);
    check("t6_id_rst", out_id, 0);
    check("t6_data_rst", out_data, 0);
    reset = 1'b0;
    tick();
    check("t6_no_done", done, 0);
    grant = 4'b0001; set_len(0, 4'd0);
    tick();
    check("t6_new_valid", out_valid, 1);
    check("t6_new_id", out_id, 0);
    check("t6_new_data", out_data, 8'hA0);
    tick();
    check("t6_new_ack", data_ack, 4'b0001);
    tick();
    check("t6_new_done", done, 4'b0001);
    grant = 4'b0000;
    tick();
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
